// File: rtl/io_pkg.sv
// Shared types for the IO counter blocks: FSM state encoding and default count width.
package io_pkg;

  localparam int unsigned DefaultValueWidth = 8;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StCount = 2'd1,
    StDone  = 2'd2
  } state_t;

endpackage

// File: rtl/down_tff_chain.sv
// Loadable down-counting register built as a T-flip-flop borrow chain.
// Bit i toggles on Step when all lower bits are zero; Load overrides Step.
module down_tff_chain
  import io_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = DefaultValueWidth
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Step,
  input  logic                   Load,
  input  logic [VALUE_WIDTH-1:0] LoadValue,
  output logic [VALUE_WIDTH-1:0] value
);

  logic [VALUE_WIDTH-1:0] value_q, value_d;
  logic [VALUE_WIDTH-1:0] borrow;

  always_comb begin
    borrow    = '0;
    borrow[0] = Step;
    for (int i = 1; i < VALUE_WIDTH; i++) begin
      borrow[i] = borrow[i-1] & ~value_q[i-1];
    end
    value_d = Load ? LoadValue : (value_q ^ borrow);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule

// File: rtl/io_down_counter.sv
// Loadable transfer-length down-counter with Busy/Done/Underflow status.
// Optional IO_DOWN_COUNTER_AUTORELOAD_EN reloads the last nonzero count on terminal count.
module io_down_counter
  import io_pkg::*;
#(
  parameter int unsigned VALUE_WIDTH = DefaultValueWidth
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   Load,
  input  logic [VALUE_WIDTH-1:0] LoadValue,
  input  logic                   Enable,
  output logic [VALUE_WIDTH-1:0] value,
  output logic                   Busy,
  output logic                   Done,
  output logic                   Underflow
);

  localparam logic [VALUE_WIDTH-1:0] One = VALUE_WIDTH'(1);

  state_t                 state_q, state_d;
  logic                   busy_q, done_q, underflow_q, underflow_d;
  logic                   reload_hit;
  logic                   chain_step, chain_load;
  logic [VALUE_WIDTH-1:0] chain_load_value;

`ifdef IO_DOWN_COUNTER_AUTORELOAD_EN
  logic [VALUE_WIDTH-1:0] shadow_q;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      shadow_q <= '0;
    end else if (Load && (LoadValue != '0)) begin
      shadow_q <= LoadValue;
    end
  end
`endif

  always_comb begin
    state_d          = state_q;
    underflow_d      = underflow_q;
    reload_hit       = 1'b0;
    chain_step       = 1'b0;
    chain_load       = 1'b0;
    chain_load_value = LoadValue;

    // Load wins over Enable in every state and clears the sticky error.
    if (Load) begin
      chain_load  = 1'b1;
      underflow_d = 1'b0;
      state_d     = (LoadValue == '0) ? StDone : StCount;
    end else begin
      unique case (state_q)
        StIdle: ;
        StCount: begin
          if (Enable) begin
            if (value == One) begin
`ifdef IO_DOWN_COUNTER_AUTORELOAD_EN
              chain_load       = 1'b1;
              chain_load_value = shadow_q;
              reload_hit       = 1'b1;
`else
              chain_step = 1'b1;
              state_d    = StDone;
`endif
            end else begin
              chain_step = 1'b1;
            end
          end
        end
        StDone: begin
          if (Enable) underflow_d = 1'b1;
          state_d = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q     <= StIdle;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d == StCount);
      done_q      <= (state_d == StDone) || reload_hit;
      underflow_q <= underflow_d;
    end
  end

  down_tff_chain #(
    .VALUE_WIDTH(VALUE_WIDTH)
  ) u_chain (
    .CLK      (CLK),
    .RST      (RST),
    .Step     (chain_step),
    .Load     (chain_load),
    .LoadValue(chain_load_value),
    .value    (value)
  );

  assign Busy      = busy_q;
  assign Done      = done_q;
  assign Underflow = underflow_q;

endmodule

// File: tb/tb_io_down_counter.sv
// Directed bench for io_down_counter; expected outputs are queued per step and checked after the edge.
module tb_io_down_counter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Load;
  logic [7:0] LoadValue;
  logic       Enable;
  logic [7:0] value;
  logic       Busy;
  logic       Done;
  logic       Underflow;

  typedef struct packed {
    logic [7:0] v;
    logic       b;
    logic       d;
    logic       u;
  } exp_t;

  exp_t  sb[$];
  string tags[$];
  int    tests = 0;
  int    fails = 0;

  always #5 CLK = ~CLK;

  io_down_counter #(
    .VALUE_WIDTH(8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .Load     (Load),
    .LoadValue(LoadValue),
    .Enable   (Enable),
    .value    (value),
    .Busy     (Busy),
    .Done     (Done),
    .Underflow(Underflow)
  );

  task automatic check_out();
    exp_t  e;
    string t;
    e = sb.pop_front();
    t = tags.pop_front();
    tests++;
    assert (value === e.v) else begin
      fails++;
      $error("FAIL %s value: got %0d expected %0d", t, value, e.v);
    end
    tests++;
    assert (Busy === e.b) else begin
      fails++;
      $error("FAIL %s Busy: got %b expected %b", t, Busy, e.b);
    end
    tests++;
    assert (Done === e.d) else begin
      fails++;
      $error("FAIL %s Done: got %b expected %b", t, Done, e.d);
    end
    tests++;
    assert (Underflow === e.u) else begin
      fails++;
      $error("FAIL %s Underflow: got %b expected %b", t, Underflow, e.u);
    end
  endtask

  // Drive one cycle of inputs, queue the outputs expected after the edge, then check them.
  task automatic step(input logic rst, input logic ld, input logic [7:0] lv, input logic en,
                      input logic [7:0] ev, input logic eb, input logic ed, input logic eu,
                      input string tag);
    RST       = rst;
    Load      = ld;
    LoadValue = lv;
    Enable    = en;
    sb.push_back('{ev, eb, ed, eu});
    tags.push_back(tag);
    @(posedge CLK);
    #1;
    check_out();
  endtask

  initial begin
    RST       = 1'b0;
    Load      = 1'b0;
    LoadValue = 8'd0;
    Enable    = 1'b0;

    // Reset overrides Load; Enable in IDLE is ignored.
    step(1'b0, 1'b1, 8'd5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rst_load1");
    step(1'b0, 1'b1, 8'd5, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rst_load2");
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "idle_en");

    // Zero-length transfer completes immediately.
    step(1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "zero_load");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "zero_idle");

`ifdef IO_DOWN_COUNTER_AUTORELOAD_EN
    step(1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "ar_load");
    for (int i = 1; i <= 9; i++) begin
      step(1'b1, 1'b0, 8'd0, 1'b1, (i % 3 == 0) ? 8'd3 : 8'(3 - (i % 3)), 1'b1,
           (i % 3 == 0), 1'b0, "ar_tick");
    end
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "ar_hold");
    step(1'b1, 1'b1, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1, 1'b0, "ar_zero");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "ar_idle");
`else
    // Basic count 3,2,1,0.
    step(1'b1, 1'b1, 8'd3, 1'b0, 8'd3, 1'b1, 1'b0, 1'b0, "basic_load");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd2, 1'b1, 1'b0, 1'b0, "basic_en1");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "basic_hold");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, "basic_en2");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "basic_en3");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "basic_idle");

    // Reload mid-count with simultaneous Enable: Load wins.
    step(1'b1, 1'b1, 8'd10, 1'b0, 8'd10, 1'b1, 1'b0, 1'b0, "rl_load10");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd9, 1'b1, 1'b0, 1'b0, "rl_en1");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd8, 1'b1, 1'b0, 1'b0, "rl_en2");
    step(1'b1, 1'b1, 8'd4, 1'b1, 8'd4, 1'b1, 1'b0, 1'b0, "rl_load4_en");
    for (int k = 1; k <= 3; k++) begin
      step(1'b1, 1'b0, 8'd0, 1'b1, 8'(4 - k), 1'b1, 1'b0, 1'b0, "rl_count");
    end
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "rl_done");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "rl_idle");

    // Full range: 255 Enables to terminal count.
    step(1'b1, 1'b1, 8'd255, 1'b0, 8'd255, 1'b1, 1'b0, 1'b0, "full_load");
    for (int k = 1; k <= 254; k++) begin
      step(1'b1, 1'b0, 8'd0, 1'b1, 8'(255 - k), 1'b1, 1'b0, 1'b0, "full_step");
    end
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "full_done");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "full_idle");

    // Underflow: Enable during DONE, sticky until Load.
    step(1'b1, 1'b1, 8'd1, 1'b0, 8'd1, 1'b1, 1'b0, 1'b0, "uf_load1");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "uf_done");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "uf_set");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b1, "uf_sticky");
    step(1'b1, 1'b1, 8'd2, 1'b0, 8'd2, 1'b1, 1'b0, 1'b0, "uf_clear");

    // Load accepted in the DONE cycle; zero load with Enable in COUNT goes to DONE.
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd1, 1'b1, 1'b0, 1'b0, "dl_en1");
    step(1'b1, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "dl_done");
    step(1'b1, 1'b1, 8'd5, 1'b0, 8'd5, 1'b1, 1'b0, 1'b0, "dl_load5");
    step(1'b1, 1'b1, 8'd0, 1'b1, 8'd0, 1'b0, 1'b1, 1'b0, "dl_zero_en");
    step(1'b1, 1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, "dl_idle");

    // Synchronous reset mid-count.
    step(1'b1, 1'b1, 8'd7, 1'b0, 8'd7, 1'b1, 1'b0, 1'b0, "mr_load");
    step(1'b0, 1'b0, 8'd0, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, "mr_reset");
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/io_down_counter.md
Name: io_down_counter

Overview:
- Loadable down-counter for the IO module. It is the counterpart of the IO up-counter: it counts a transfer length down to zero instead of counting received items up.
- The IO controller loads a word count and pulses Enable once per word sent. The block reports Busy while words remain, then pulses Done on terminal count.
- The counting datapath is a T-flip-flop borrow chain: bit i toggles when stepping and all lower bits are 0. This mirrors the carry chain of the up-counter.

Parameters:
- VALUE_WIDTH, 8, width of the count register and of LoadValue.

Ports:
- CLK  input  1  single clock, rising edge.
- RST  input  1  reset, synchronous, active-low. One clock, CLK; RST is sampled only on the CLK rising edge.
- Load  input  1  load request; captures LoadValue.
- LoadValue  input  VALUE_WIDTH  count to load (unsigned).
- Enable  input  1  step request; decrement by 1 when counting.
- value  output  VALUE_WIDTH  current remaining count (registered).
- Busy  output  1  high while in COUNT state.
- Done  output  1  one-cycle pulse when count reaches zero.
- Underflow  output  1  sticky error: Enable seen while in DONE state; cleared by Load or reset.

Behaviour:
- Reset (RST=0 at a rising edge): value=0, Busy=0, Done=0, Underflow=0, state=IDLE. Reset overrides Load and Enable in the same cycle.
- States: IDLE, COUNT, DONE; encoding comes from the shared package.
- IDLE:
  - Load=1 with LoadValue!=0: value<=LoadValue, go to COUNT.
  - Load=1 with LoadValue==0: value<=0, go to DONE (zero-length transfer completes immediately).
  - Enable alone is ignored; value holds.
- COUNT:
  - Load=1 has priority over Enable. It reloads value<=LoadValue and restarts; LoadValue==0 goes to DONE.
  - Enable=1 with value>1: value<=value-1, stay in COUNT.
  - Enable=1 with value==1: value<=0, go to DONE.
  - Enable=0: hold.
- DONE:
  - Lasts exactly one cycle, with Done=1 and Busy=0, then returns to IDLE.
  - Load=1 in DONE is accepted, with the same rules as in IDLE; Done is still 1 in that cycle.
  - Enable=1 in DONE sets Underflow; value stays 0. It never wraps to all-ones.
- Outputs:
  - Busy and Done are registered functions of state, so both are valid in the cycle after the causing edge.
  - Latency from Load to Busy=1 is 1 cycle. Latency from the final Enable to Done=1 is 1 cycle.
- Arithmetic is modulo 2^VALUE_WIDTH in the chain, but the FSM guarantees no decrement from 0.
- Max load is 2^VALUE_WIDTH-1. That load needs exactly that many Enable pulses to reach DONE.

Optional Feature:
- Macro: IO_DOWN_COUNTER_AUTORELOAD_EN.
- When defined:
  - The last nonzero LoadValue is stored in a shadow register.
  - On reaching zero, Done pulses for one cycle and value<=shadow in that same transition, with state going to COUNT (not IDLE).
  - Busy stays 1 continuously, giving a periodic tick every LoadValue Enables.
  - A zero load still goes to DONE, then IDLE.
- When undefined: no shadow register; behaviour is exactly as in Behaviour above.

Decomposition:
- Package io_pkg holds the state typedef (IDLE, COUNT, DONE) and the default width constant.
- One sub-module, down_tff_chain (VALUE_WIDTH):
  - Ports: CLK, RST, Step, Load, LoadValue, value.
  - Borrow chain: bit i toggles when Step is high and bits [i-1:0] are all 0; Load has priority.
- The FSM, Underflow and autoreload logic live in io_down_counter.

Test Plan:
- Reset/idle: hold RST=0 for 2 cycles with Load=1, LoadValue=5 -> value=0, Busy=0, Done=0. Release RST, pulse Enable x3 -> value stays 0.
- Basic count: Load 3, then Enable every cycle -> value 3,2,1,0; Busy high for 3 cycles; Done=1 exactly one cycle after the third Enable, then IDLE.
- Reload mid-count, Load+Enable simultaneous:
  - Load 10, two Enables -> value=8.
  - Load=1 with LoadValue=4 together with Enable=1 -> value=4, not 7 or 3.
- Zero load and full range (VALUE_WIDTH=8):
  - Load 0 -> Done pulses next cycle, Busy never high.
  - Load 255 -> exactly 255 Enables before Done; value never shows 255 after a step.
- Underflow: Load 1, Enable, then Enable in the DONE cycle -> Underflow=1 and value=0. A subsequent Load 2 clears Underflow.
- With IO_DOWN_COUNTER_AUTORELOAD_EN: Load 3, 9 continuous Enables -> Done pulses after Enables 3, 6 and 9; Busy stays 1; value sequence 3,2,1,3,2,1,...
